wb_slave_regs: RTL and testbench
================================

Name: wb_slave_regs

Overview:
- Wishbone classic, single-cycle-per-transfer slave: the responder end of the Wishbone bus.
- Serves a byte-lane-writable bank of 32-bit registers with a configurable number of wait states.
- Used as the bus target that the Wishbone master VIP and DUT masters talk to in the USB environment.
- Drives ACK_O/DAT_O from CYC_I/STB_I/WE_I/SEL_I/ADR_I/DAT_I.

Parameters:
- DEPTH, 16, number of 32-bit registers (power of two, 2..256).
- BASE_ADDR, 32'h0000_0000, byte base address of the bank (aligned to DEPTH*4).
- WAIT_CYCLES, 0, wait states inserted before ACK_O (0..15).

Ports:
- CLK_I  in  1  bus clock; all logic on rising edge.
- RST_I  in  1  reset, asynchronous assert, active-low (0 = reset).
- CYC_I  in  1  bus cycle valid.
- STB_I  in  1  strobe, transfer request.
- WE_I  in  1  1 = write, 0 = read.
- SEL_I  in  4  byte lane enables; bit n selects DAT[8n+7:8n].
- ADR_I  in  32  byte address.
- DAT_I  in  32  write data.
- DAT_O  out  32  read data, valid while ACK_O=1.
- ACK_O  out  1  transfer acknowledge, one-cycle pulse.

Behaviour:
- Reset (RST_I=0, any time): state IDLE, ACK_O=0, DAT_O=0, wait counter=0, all registers=0. Takes effect immediately, without waiting for a clock edge.
- A request is CYC_I & STB_I high at a rising edge.
- Decode:
  - hit = (ADR_I[31:2+log2(DEPTH)] == BASE_ADDR[31:2+log2(DEPTH)]).
  - index = ADR_I[1+log2(DEPTH):2].
  - ADR_I[1:0] ignored.
- FSM states: IDLE, WAIT, ACK.
  - IDLE: on a request, latch WE/SEL/index/hit/DAT_I and load counter=WAIT_CYCLES. Go to WAIT if WAIT_CYCLES>0, else ACK.
  - WAIT: each cycle, if CYC_I & STB_I, decrement the counter and go to ACK when counter==1. If CYC_I=0 or STB_I=0, abort to IDLE: no write, no ACK.
  - ACK: ACK_O=1 for exactly one cycle, then unconditionally IDLE.
- Transition into ACK (the same edge that sets ACK_O):
  - Write & hit: reg[index] byte lanes where SEL=1 take DAT_I bytes; other lanes are unchanged.
  - Read & hit: DAT_O = reg[index], full 32 bits regardless of SEL.
  - Miss: acked normally, write discarded, DAT_O=0.
- Latency: request sampled at edge N; ACK_O high during cycle N+1+WAIT_CYCLES.
- Throughput: at least one IDLE cycle between ACKs. Back-to-back requests take 2+WAIT_CYCLES cycles each.
- DAT_O holds its last value after ACK (don't-care for the bus, deterministic for the bench). It returns to 0 only on a miss read or reset.
- SEL_I=0 write: acked, no register changes.
- CYC_I=1 & STB_I=0 in IDLE: no action.
- Request-field changes during WAIT are ignored; latched values are used.

Decomposition:
- Shared package wb_pkg holds:
  - WB_AW=32, WB_DW=32, WB_SW=4.
  - typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_slv_state_e.
  - typedef struct for the latched request {we, sel, idx, hit, wdata}.
- One natural sub-module: wb_regbank (DEPTH x 32 storage, byte-enable write port, combinational read, async active-low clear).

Test Plan:
- Reset then read: RST_I=0→1, read ADR=0x8 → ACK one cycle after the request, DAT_O=0x0000_0000, ACK_O low the following cycle.
- Full write/readback, WAIT_CYCLES=0: write 0xDEADBEEF to 0x4 with SEL=4'hF → ACK at N+1; read 0x4 → DAT_O=0xDEADBEEF.
- Byte lanes: after the previous scenario, write 0x1122_3344 to 0x4 with SEL=4'b0101 → readback 0xDE22BE44.
- Wait states and abort, WAIT_CYCLES=3:
  - Write 0xA5A5A5A5 to 0xC → ACK exactly 4 cycles after the request edge.
  - Repeat with 0x5A5A5A5A but drop STB_I after 2 cycles → no ACK; reg[3] still 0xA5A5A5A5.
- Out of range, BASE_ADDR=0x1000, DEPTH=16:
  - Write 0xFFFFFFFF to 0x2000 → acked; all registers unchanged.
  - Read 0x2000 → DAT_O=0.
  - Read 0x103C → reg[15].
- Mid-transfer reset, WAIT_CYCLES=2: drive RST_I low during WAIT of a write → ACK_O=0 immediately, no write. After release, the first request behaves per the latency rule.

Source files
------------

// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths, slave FSM states and the latched request record
package wb_pkg;
  localparam int WB_AW = 32;
  localparam int WB_DW = 32;
  localparam int WB_SW = 4;
  typedef enum logic [1:0] {IDLE, WAIT, ACK} wb_slv_state_e;
  typedef struct packed {
    logic             we;
    logic [WB_SW-1:0] sel;
    logic [7:0]       idx;
    logic             hit;
    logic [WB_DW-1:0] wdata;
  } wb_req_t;
endpackage

// File: rtl/wb_regbank.sv
// wb_regbank: DEPTH x 32 storage; ports clk, rst_n (async clear), idx, be (byte write enables), wdata, rdata (combinational)
module wb_regbank
  import wb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] idx,
  input  logic [WB_SW-1:0]         be,
  input  logic [WB_DW-1:0]         wdata,
  output logic [WB_DW-1:0]         rdata
);
  logic [DEPTH-1:0][WB_DW-1:0] mem_q, mem_d;
  always_comb begin
    mem_d = mem_q;
    for (int b = 0; b < WB_SW; b++)
      if (be[b]) mem_d[idx][8*b +: 8] = wdata[8*b +: 8];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mem_q <= '0;
    else mem_q <= mem_d;
  assign rdata = mem_q[idx];
endmodule

// File: rtl/wb_slave_regs.sv
// wb_slave_regs: Wishbone classic register slave; in CLK_I RST_I(active-low async) CYC_I STB_I WE_I SEL_I ADR_I DAT_I, out DAT_O ACK_O
module wb_slave_regs
  import wb_pkg::*;
#(
  parameter int               DEPTH       = 16,
  parameter logic [WB_AW-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int               WAIT_CYCLES = 0
) (
  input  logic             CLK_I,
  input  logic             RST_I,
  input  logic             CYC_I,
  input  logic             STB_I,
  input  logic             WE_I,
  input  logic [WB_SW-1:0] SEL_I,
  input  logic [WB_AW-1:0] ADR_I,
  input  logic [WB_DW-1:0] DAT_I,
  output logic [WB_DW-1:0] DAT_O,
  output logic             ACK_O
);
  localparam int IW = $clog2(DEPTH);
  wb_slv_state_e    state_q, state_d;
  wb_req_t          req_q, req_d, live, cur;
  logic [3:0]       cnt_q, cnt_d;
  logic [WB_DW-1:0] dat_q, dat_d, rdata;
  logic [WB_SW-1:0] be;
  logic             go_ack;
  logic             unused_ok;
  always_comb begin
    live = '{we: WE_I, sel: SEL_I, idx: 8'(ADR_I[1+IW:2]),
             hit: ADR_I[WB_AW-1:2+IW] == BASE_ADDR[WB_AW-1:2+IW], wdata: DAT_I};
    cur = state_q == IDLE ? live : req_q;
    state_d = state_q;
    req_d = req_q;
    cnt_d = cnt_q;
    case (state_q)
      IDLE: if (CYC_I && STB_I) begin
        req_d = live;
        cnt_d = 4'(WAIT_CYCLES);
        state_d = WAIT_CYCLES > 0 ? WAIT : ACK;
      end
      WAIT: if (!(CYC_I && STB_I)) state_d = IDLE;
        else begin
          cnt_d = cnt_q - 4'd1;
          state_d = cnt_q == 4'd1 ? ACK : WAIT;
        end
      default: state_d = IDLE;
    endcase
    go_ack = state_d == ACK && state_q != ACK;
    be = go_ack && cur.we && cur.hit ? cur.sel : '0;
    dat_d = go_ack && !cur.we ? (cur.hit ? rdata : '0) : dat_q;
  end
  always_ff @(posedge CLK_I or negedge RST_I)
    if (!RST_I) begin
      state_q <= IDLE;
      req_q <= '0;
      cnt_q <= '0;
      dat_q <= '0;
    end else begin
      state_q <= state_d;
      req_q <= req_d;
      cnt_q <= cnt_d;
      dat_q <= dat_d;
    end
  wb_regbank #(.DEPTH(DEPTH)) u_bank (
    .clk  (CLK_I),
    .rst_n(RST_I),
    .idx  (cur.idx[IW-1:0]),
    .be   (be),
    .wdata(cur.wdata),
    .rdata(rdata)
  );
  assign ACK_O = state_q == ACK;
  assign DAT_O = dat_q;
  assign unused_ok = ^{ADR_I[1:0], cur.idx};
endmodule

// File: tb/tb_wb_slave_regs.sv
// tb_wb_slave_regs: scoreboard bench over four slave instances with different base/wait-state settings
module tb_wb_slave_regs;
  typedef struct {
    int          inst;
    int          cyc;
    logic        rd;
    logic [31:0] data;
    int          tag;
  } exp_t;
  logic        clk = 1'b0;
  int          cyc_cnt = 0;
  int          nvec = 0;
  int          nbad = 0;
  logic        rst_n[4], cyc[4], stb[4], we[4], ack[4];
  logic [3:0]  sel[4];
  logic [31:0] adr[4], dat_i[4], dat_o[4];
  exp_t        sb[$];
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  for (genvar g = 0; g < 4; g++) begin : g_dut
    wb_slave_regs #(
      .DEPTH(16),
      .BASE_ADDR(g == 2 ? 32'h0000_1000 : 32'h0000_0000),
      .WAIT_CYCLES(g == 1 ? 3 : g == 3 ? 2 : 0)
    ) u_dut (
      .CLK_I(clk), .RST_I(rst_n[g]), .CYC_I(cyc[g]), .STB_I(stb[g]), .WE_I(we[g]),
      .SEL_I(sel[g]), .ADR_I(adr[g]), .DAT_I(dat_i[g]), .DAT_O(dat_o[g]), .ACK_O(ack[g])
    );
  end
  function automatic int wc(input int i);
    return i == 1 ? 3 : i == 3 ? 2 : 0;
  endfunction
  always @(negedge clk)
    for (int i = 0; i < 4; i++)
      if (ack[i] === 1'b1) begin
        exp_t e;
        nvec++;
        if (sb.size() == 0) begin
          nbad++;
          $display("FAIL unexpected_ack inst=%0d cycle=%0d got ack=1 required ack=0", i, cyc_cnt);
        end else begin
          e = sb.pop_front();
          if (e.inst != i || e.cyc != cyc_cnt || (e.rd && dat_o[i] !== e.data)) begin
            nbad++;
            $display("FAIL ack_tag%0d got inst=%0d cycle=%0d dat=%h required inst=%0d cycle=%0d dat=%h",
                     e.tag, i, cyc_cnt, dat_o[i], e.inst, e.cyc, e.rd ? e.data : dat_o[i]);
          end
        end
      end
  task automatic xfer(input int i, input logic w, input logic [3:0] s, input logic [31:0] a,
                      input logic [31:0] d, input int tag, output int ack_cyc);
    exp_t e;
    int n;
    cyc[i] = 1'b1; stb[i] = 1'b1; we[i] = w; sel[i] = s; adr[i] = a; dat_i[i] = d;
    @(posedge clk); #1;
    e.inst = i; e.cyc = cyc_cnt + wc(i); e.rd = !w; e.data = d; e.tag = tag;
    sb.push_back(e);
    n = 0;
    ack_cyc = -1;
    while (ack_cyc < 0 && n < 40) begin
      @(negedge clk);
      n++;
      if (ack[i] === 1'b1) ack_cyc = cyc_cnt;
    end
    if (ack_cyc < 0) begin
      nvec++; nbad++;
      $display("FAIL ack_timeout_tag%0d got no ack in 40 cycles required ack", tag);
      sb.delete();
    end
    @(posedge clk); #1;
  endtask
  task automatic idle(input int i);
    cyc[i] = 1'b0; stb[i] = 1'b0;
    @(posedge clk); #1;
  endtask
  task automatic test_reset;
    int a;
    #2;
    for (int i = 0; i < 4; i++) begin
      nvec += 2;
      if (ack[i] !== 1'b0) begin nbad++; $display("FAIL reset_ack inst=%0d got %b required 0", i, ack[i]); end
      if (dat_o[i] !== 32'h0) begin nbad++; $display("FAIL reset_dat inst=%0d got %h required 0", i, dat_o[i]); end
    end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) rst_n[i] = 1'b1;
    @(posedge clk); #1;
    xfer(0, 1'b0, 4'hF, 32'h8, 32'h0, 1, a);
    nvec++;
    if (ack[0] !== 1'b0) begin nbad++; $display("FAIL ack_one_cycle got %b required 0", ack[0]); end
    idle(0);
  endtask
  task automatic test_write_read;
    int a;
    xfer(0, 1'b1, 4'hF, 32'h4, 32'hDEAD_BEEF, 2, a);
    idle(0);
    xfer(0, 1'b0, 4'hF, 32'h4, 32'hDEAD_BEEF, 3, a);
    idle(0);
  endtask
  task automatic test_byte_lanes;
    int a;
    xfer(0, 1'b1, 4'b0101, 32'h4, 32'h1122_3344, 4, a);
    idle(0);
    xfer(0, 1'b0, 4'h0, 32'h4, 32'hDE22_BE44, 5, a);
    idle(0);
    xfer(0, 1'b1, 4'h0, 32'h4, 32'hAAAA_AAAA, 6, a);
    idle(0);
    xfer(0, 1'b0, 4'hF, 32'h7, 32'hDE22_BE44, 7, a);
    idle(0);
  endtask
  task automatic test_back_to_back;
    int a1, a2;
    xfer(0, 1'b1, 4'hF, 32'h0, 32'h0102_0304, 8, a1);
    xfer(0, 1'b0, 4'hF, 32'h0, 32'h0102_0304, 9, a2);
    idle(0);
    nvec++;
    if (a2 - a1 != 2) begin nbad++; $display("FAIL b2b_gap_w0 got %0d required 2", a2 - a1); end
    xfer(1, 1'b1, 4'hF, 32'h8, 32'h0000_00AB, 10, a1);
    xfer(1, 1'b0, 4'hF, 32'h8, 32'h0000_00AB, 11, a2);
    idle(1);
    nvec++;
    if (a2 - a1 != 5) begin nbad++; $display("FAIL b2b_gap_w3 got %0d required 5", a2 - a1); end
  endtask
  task automatic test_wait_abort;
    int a;
    xfer(1, 1'b1, 4'hF, 32'hC, 32'hA5A5_A5A5, 12, a);
    idle(1);
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; sel[1] = 4'hF; adr[1] = 32'hC; dat_i[1] = 32'h5A5A_5A5A;
    repeat (3) @(posedge clk);
    #1 stb[1] = 1'b0;
    repeat (6) begin
      @(negedge clk);
      nvec++;
      if (ack[1] !== 1'b0) begin nbad++; $display("FAIL abort_ack got %b required 0", ack[1]); end
    end
    cyc[1] = 1'b0;
    @(posedge clk); #1;
    xfer(1, 1'b0, 4'hF, 32'hC, 32'hA5A5_A5A5, 13, a);
    idle(1);
  endtask
  task automatic test_out_of_range;
    int a;
    xfer(2, 1'b1, 4'hF, 32'h103C, 32'h0F0F_1234, 14, a);
    xfer(2, 1'b1, 4'hF, 32'h1000, 32'hCAFE_F00D, 15, a);
    xfer(2, 1'b0, 4'hF, 32'h1000, 32'hCAFE_F00D, 16, a);
    xfer(2, 1'b1, 4'hF, 32'h2000, 32'hFFFF_FFFF, 17, a);
    nvec++;
    if (dat_o[2] !== 32'hCAFE_F00D) begin nbad++; $display("FAIL miss_write_hold got %h required cafef00d", dat_o[2]); end
    xfer(2, 1'b0, 4'hF, 32'h2000, 32'h0, 18, a);
    xfer(2, 1'b0, 4'hF, 32'h103C, 32'h0F0F_1234, 19, a);
    xfer(2, 1'b0, 4'hF, 32'h1000, 32'hCAFE_F00D, 20, a);
    xfer(2, 1'b0, 4'hF, 32'h1004, 32'h0, 21, a);
    idle(2);
  endtask
  task automatic test_mid_reset;
    int a;
    xfer(3, 1'b1, 4'hF, 32'h10, 32'h0000_0077, 22, a);
    idle(3);
    xfer(3, 1'b0, 4'hF, 32'h10, 32'h0000_0077, 23, a);
    idle(3);
    nvec++;
    if (dat_o[3] !== 32'h77) begin nbad++; $display("FAIL dat_hold got %h required 00000077", dat_o[3]); end
    rst_n[3] = 1'b0;
    #1;
    nvec++;
    if (dat_o[3] !== 32'h0) begin nbad++; $display("FAIL async_reset_dat got %h required 0", dat_o[3]); end
    @(posedge clk); #1;
    rst_n[3] = 1'b1;
    @(posedge clk); #1;
    cyc[3] = 1'b1; stb[3] = 1'b1; we[3] = 1'b1; sel[3] = 4'hF; adr[3] = 32'h10; dat_i[3] = 32'h0000_0099;
    @(posedge clk); #1;
    rst_n[3] = 1'b0;
    cyc[3] = 1'b0; stb[3] = 1'b0;
    #1;
    nvec++;
    if (ack[3] !== 1'b0) begin nbad++; $display("FAIL reset_in_wait_ack got %b required 0", ack[3]); end
    repeat (2) @(posedge clk);
    #1 rst_n[3] = 1'b1;
    repeat (3) begin
      @(negedge clk);
      nvec++;
      if (ack[3] !== 1'b0) begin nbad++; $display("FAIL post_reset_ack got %b required 0", ack[3]); end
    end
    @(posedge clk); #1;
    xfer(3, 1'b0, 4'hF, 32'h10, 32'h0, 24, a);
    idle(3);
  endtask
  task automatic test_drain;
    repeat (4) @(posedge clk);
    nvec++;
    if (sb.size() != 0) begin nbad++; $display("FAIL scoreboard_drain got %0d pending required 0", sb.size()); end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got timeout required completion");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      rst_n[i] = 1'b0; cyc[i] = 1'b0; stb[i] = 1'b0; we[i] = 1'b0;
      sel[i] = 4'h0; adr[i] = 32'h0; dat_i[i] = 32'h0;
    end
    test_reset;
    test_write_read;
    test_byte_lanes;
    test_back_to_back;
    test_wait_abort;
    test_out_of_range;
    test_mid_reset;
    test_drain;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
